reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 129 ++++++++++++
 tb/tb_reset_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises pin-reset release, merges software/watchdog requests and
// releases bus, peripheral and core domain resets in a fixed, staggered order.
module reset_sequencer #(
    parameter int unsigned SYNC_DEPTH  = 5,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 4
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_sw_rst_req,
    input  logic       i_wdt_rst_req,
    output logic       o_bus_rstn,
    output logic       o_periph_rstn,
    output logic       o_core_rstn,
    output logic       o_rst_done,
    output logic [1:0] o_rst_cause
);

    localparam int unsigned CntMax = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StAssert    = 3'd0,
        StRelBus    = 3'd1,
        StRelPeriph = 3'd2,
        StRelCore   = 3'd3,
        StRun       = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        cause_q, cause_d;
    logic [SYNC_DEPTH-1:0] sync_q;
    logic              rel_sync;
    logic              bus_q, periph_q, core_q, done_q;
    logic              bus_d, periph_d, core_d, done_d;

    // Only the pin reset clears the chain; requests restart the FSM but not this.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    assign rel_sync = sync_q[SYNC_DEPTH-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        if (i_sw_rst_req || i_wdt_rst_req) begin
            state_d = StAssert;
            cnt_d   = '0;
            cause_d = i_wdt_rst_req ? 2'b10 : 2'b01;
        end else begin
            case (state_q)
                StAssert: begin
                    if (!rel_sync) begin
                        cnt_d = '0;
                    end else if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
                        state_d = StRelBus;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StRelBus: begin
                    if (cnt_q == CntW'(STAGE_GAP - 1)) begin
                        state_d = StRelPeriph;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StRelPeriph: begin
                    if (cnt_q == CntW'(STAGE_GAP - 1)) begin
                        state_d = StRelCore;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StRelCore: state_d = StRun;
                StRun:     state_d = StRun;
                default: begin
                    state_d = StAssert;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_comb begin
        bus_d    = (state_d != StAssert);
        periph_d = (state_d == StRelPeriph) || (state_d == StRelCore) || (state_d == StRun);
        core_d   = (state_d == StRelCore) || (state_d == StRun);
        done_d   = (state_d == StRun);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= StAssert;
            cnt_q    <= '0;
            cause_q  <= 2'b00;
            bus_q    <= 1'b0;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            bus_q    <= bus_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            done_q   <= done_d;
        end
    end

    assign o_bus_rstn    = bus_q;
    assign o_periph_rstn = periph_q;
    assign o_core_rstn   = core_q;
    assign o_rst_done    = done_q;
    assign o_rst_cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters; outputs sampled 1 time unit
// after each rising edge and compared against hand-derived release edges.
module tb_reset_sequencer;

    logic       i_clk;
    logic       i_rstn;
    logic       i_sw_rst_req;
    logic       i_wdt_rst_req;
    logic       o_bus_rstn;
    logic       o_periph_rstn;
    logic       o_core_rstn;
    logic       o_rst_done;
    logic [1:0] o_rst_cause;

    int n_checks = 0;
    int n_fail   = 0;

    reset_sequencer #(
        .SYNC_DEPTH (5),
        .HOLD_CYCLES(16),
        .STAGE_GAP  (4)
    ) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_sw_rst_req (i_sw_rst_req),
        .i_wdt_rst_req(i_wdt_rst_req),
        .o_bus_rstn   (o_bus_rstn),
        .o_periph_rstn(o_periph_rstn),
        .o_core_rstn  (o_core_rstn),
        .o_rst_done   (o_rst_done),
        .o_rst_cause  (o_rst_cause)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Compares {bus, periph, core, done, cause[1:0]}.
    task automatic check(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {o_bus_rstn, o_periph_rstn, o_core_rstn, o_rst_done, o_rst_cause};
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (bus,periph,core,done,cause)", tag, obs,
                   exp);
        end
    endtask

    // Steps ncyc edges; bus releases after edge bus_e, periph 4 later, core 8, done 9.
    task automatic seq_check(input string tag, input int bus_e, input int ncyc,
                             input logic [1:0] cause);
        logic [5:0] exp;
        for (int e = 1; e <= ncyc; e++) begin
            tick();
            exp = {(e >= bus_e), (e >= bus_e + 4), (e >= bus_e + 8), (e >= bus_e + 9), cause};
            check($sformatf("%s_e%0d", tag, e), exp);
        end
    endtask

    initial begin
        i_rstn        = 1'b0;
        i_sw_rst_req  = 1'b0;
        i_wdt_rst_req = 1'b0;
        #2;
        check("reset_async", 6'b0000_00);
        tick();
        tick();
        check("reset_held", 6'b0000_00);

        // Power-on: first edge with i_rstn high is edge 1.
        i_rstn = 1'b1;
        seq_check("poweron", 21, 34, 2'b00);

        // Software pulse in RUN.
        i_sw_rst_req = 1'b1;
        tick();
        i_sw_rst_req = 1'b0;
        check("sw_assert", 6'b0000_01);
        seq_check("sw_seq", 16, 28, 2'b01);

        // Simultaneous requests: watchdog wins.
        i_sw_rst_req  = 1'b1;
        i_wdt_rst_req = 1'b1;
        tick();
        i_sw_rst_req  = 1'b0;
        i_wdt_rst_req = 1'b0;
        check("both_assert", 6'b0000_10);
        seq_check("both_seq", 16, 28, 2'b10);

        // Software request, then watchdog while in REL_PERIPH.
        i_sw_rst_req = 1'b1;
        tick();
        i_sw_rst_req = 1'b0;
        check("pre_wdt_assert", 6'b0000_01);
        seq_check("pre_wdt_seq", 16, 22, 2'b01);
        i_wdt_rst_req = 1'b1;
        tick();
        i_wdt_rst_req = 1'b0;
        check("wdt_periph_drop", 6'b0000_10);
        seq_check("wdt_seq", 16, 28, 2'b10);

        // Short pin-reset glitch in RUN: asynchronous drop, cause cleared.
        i_rstn = 1'b0;
        #3;
        check("glitch_async", 6'b0000_00);
        i_rstn = 1'b1;
        seq_check("glitch_seq", 21, 32, 2'b00);

        // Request held for 40 edges keeps everything in reset.
        i_sw_rst_req = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            check($sformatf("held_%0d", i), 6'b0000_01);
        end
        i_sw_rst_req = 1'b0;
        seq_check("held_seq", 16, 28, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
